// File: rtl/wptr_handler.sv
// wptr_handler: write-domain pointer and flag controller for an async FIFO.
// Advances binary/Gray write pointers, synchronizes the read Gray pointer,
// and produces registered full, almost_full, fill level and sticky overflow.
module wptr_handler #(
  parameter int PTR_WIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 w_en,
  input  logic [PTR_WIDTH:0]   g_rptr,
  output logic                 w_inc,
  output logic [PTR_WIDTH:0]   b_wptr,
  output logic [PTR_WIDTH:0]   g_wptr,
  output logic [PTR_WIDTH:0]   g_rptr_sync,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   wr_level,
  output logic                 overflow
);

  localparam int PW = PTR_WIDTH + 1;
  localparam logic [PW-1:0] C_AFULL = PW'(AFULL_THRESH);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Prefix XOR from the MSB down.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] r_b_wptr;
  logic [PW-1:0] r_g_wptr;
  logic [PW-1:0] r_sync1;
  logic [PW-1:0] r_g_rptr_sync;
  logic          r_full;
  logic          r_afull;
  logic [PW-1:0] r_level;
  logic          r_ovf;

  logic          w_accept;
  logic [PW-1:0] w_b_wptr_next;
  logic [PW-1:0] w_g_wptr_next;
  logic [PW-1:0] w_b_rptr_next;
  logic [PW-1:0] w_level_next;
  logic          w_full_next;
  logic          w_afull_next;

  // Accept a write only when the registered full flag is clear and not in reset.
  assign w_accept      = w_en & ~r_full & ~wrst;
  assign w_b_wptr_next = r_b_wptr + {{PTR_WIDTH{1'b0}}, w_accept};
  assign w_g_wptr_next = bin2gray(w_b_wptr_next);

  // Flags are computed against the value g_rptr_sync is about to take
  // (sync1), so they land on the same edge as the synchronized pointer.
  assign w_b_rptr_next = gray2bin(r_sync1);
  assign w_level_next  = w_b_wptr_next - w_b_rptr_next;
  assign w_full_next   = (w_g_wptr_next == {~r_sync1[PW-1:PW-2], r_sync1[PW-3:0]});
  assign w_afull_next  = (w_level_next >= C_AFULL);

  // --- stage: two-flop read-pointer synchronizer, no logic between stages
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_sync1       <= '0;
      r_g_rptr_sync <= '0;
    end else begin
      r_sync1       <= g_rptr;
      r_g_rptr_sync <= r_sync1;
    end
  end

  // --- stage: write pointers, level and flags registered from _next values
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_b_wptr <= '0;
      r_g_wptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_b_wptr <= w_b_wptr_next;
      r_g_wptr <= w_g_wptr_next;
      r_level  <= w_level_next;
      r_full   <= w_full_next;
      r_afull  <= w_afull_next;
      r_ovf    <= r_ovf | (w_en & r_full);
    end
  end

  assign w_inc       = w_accept;
  assign b_wptr      = r_b_wptr;
  assign g_wptr      = r_g_wptr;
  assign g_rptr_sync = r_g_rptr_sync;
  assign full        = r_full;
  assign almost_full = r_afull;
  assign wr_level    = r_level;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_wptr_handler.sv
// Testbench for wptr_handler: directed steps from the test plan plus a
// randomized writer/reader phase, checked against a count-based model.
module tb_wptr_handler;

  logic       wclk;
  logic       wrst;
  logic       w_en;
  logic [3:0] g_rptr;
  logic       w_inc;
  logic [3:0] b_wptr;
  logic [3:0] g_wptr;
  logic [3:0] g_rptr_sync;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic       overflow;

  wptr_handler #(.PTR_WIDTH(3), .AFULL_THRESH(6)) dut (
    .wclk(wclk), .wrst(wrst), .w_en(w_en), .g_rptr(g_rptr),
    .w_inc(w_inc), .b_wptr(b_wptr), .g_wptr(g_wptr),
    .g_rptr_sync(g_rptr_sync), .full(full), .almost_full(almost_full),
    .wr_level(wr_level), .overflow(overflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int errors = 0;
  int checks = 0;

  // Reference state: total writes mod 16, the raw Gray read pointer as seen
  // one and two edges ago, and the flags derived from the resulting count.
  int         m_wcnt = 0;
  logic [3:0] m_s1 = '0;
  logic [3:0] m_s2 = '0;
  int         m_lvl = 0;
  bit         m_full = 0;
  bit         m_af = 0;
  bit         m_ovf = 0;
  int         prev_b = 0;
  bit         saw_wrap = 0;

  function automatic int g2b(input logic [3:0] g);
    int b;
    b = 0;
    for (int i = 0; i < 4; i++) b = b | ((^(g >> i)) << i);
    return b;
  endfunction

  function automatic logic [3:0] b2g(input int b);
    int t;
    t = b & 15;
    return 4'(t ^ (t >> 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic rst, input logic en, input logic [3:0] gr);
    bit acc;
    @(negedge wclk);
    wrst = rst; w_en = en; g_rptr = gr;
    #1;
    acc = en & ~m_full & ~rst;
    chk("w_inc", {31'd0, w_inc}, {31'd0, acc});
    @(posedge wclk);
    if (rst) begin
      m_wcnt = 0; m_s1 = '0; m_s2 = '0; m_lvl = 0;
      m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      m_ovf  = m_ovf | (en & m_full);
      m_wcnt = (m_wcnt + int'(acc)) % 16;
      m_s2   = m_s1;
      m_s1   = gr;
      m_lvl  = (m_wcnt - g2b(m_s2)) & 15;
      m_full = (m_lvl == 8);
      m_af   = (m_lvl >= 6);
    end
    #1;
    if (prev_b == 15 && b_wptr == 4'd0) saw_wrap = 1;
    prev_b = int'(b_wptr);
    chk("b_wptr", {28'd0, b_wptr}, 32'(m_wcnt));
    chk("g_wptr", {28'd0, g_wptr}, {28'd0, b2g(m_wcnt)});
    chk("g_rptr_sync", {28'd0, g_rptr_sync}, {28'd0, m_s2});
    chk("wr_level", {28'd0, wr_level}, 32'(m_lvl));
    chk("full", {31'd0, full}, {31'd0, m_full});
    chk("almost_full", {31'd0, almost_full}, {31'd0, m_af});
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
  endtask

  initial begin
    int rbin;
    logic [3:0] gr;
    bit en;
    wrst = 1'b1; w_en = 1'b0; g_rptr = '0;

    // Reset held two cycles with a write request and a nonzero read pointer.
    tick(1, 1, 4'b0101);
    tick(1, 1, 4'b0101);
    chk("rst_full", {31'd0, full}, 32'd0);
    tick(0, 0, 4'b0101);
    chk("sync_1edge", {28'd0, g_rptr_sync}, 32'd0);
    tick(0, 0, 4'b0101);
    chk("sync_2edge", {28'd0, g_rptr_sync}, 32'b0101);

    // Fill to full with the reader idle, then one write while full.
    tick(1, 0, 4'b0000);
    for (int i = 1; i <= 9; i++) begin
      tick(0, 1, 4'b0000);
      if (i == 5) chk("afull_before", {31'd0, almost_full}, 32'd0);
      if (i == 6) chk("afull_6th", {31'd0, almost_full}, 32'd1);
      if (i == 7) chk("full_7th", {31'd0, full}, 32'd0);
      if (i == 8) begin
        chk("g_wptr_8th", {28'd0, g_wptr}, 32'b1100);
        chk("full_8th", {31'd0, full}, 32'd1);
        chk("level_8th", {28'd0, wr_level}, 32'd8);
      end
    end
    chk("b_wptr_hold", {28'd0, b_wptr}, 32'd8);
    chk("ovf_set", {31'd0, overflow}, 32'd1);

    // One read becomes visible two edges later.
    tick(0, 0, 4'b0001);
    chk("drain_pessimistic", {31'd0, full}, 32'd1);
    tick(0, 0, 4'b0001);
    chk("drain_full", {31'd0, full}, 32'd0);
    chk("drain_level", {28'd0, wr_level}, 32'd7);
    chk("drain_afull", {31'd0, almost_full}, 32'd1);

    // Write on the edge where the synchronized read pointer advances.
    tick(0, 0, 4'b0011);
    tick(0, 1, 4'b0011);
    chk("simul_level", {28'd0, wr_level}, 32'd7);
    chk("simul_full", {31'd0, full}, 32'd0);

    // Randomized writer and reader; reader never passes the true write count.
    rbin = 2;
    for (int c = 0; c < 300; c++) begin
      en = ($urandom_range(0, 3) != 0);
      if (((m_wcnt - rbin) & 15) != 0 && $urandom_range(0, 1) == 1)
        rbin = (rbin + 1) % 16;
      gr = b2g(rbin);
      tick(0, en, gr);
    end
    chk("wrap_seen", {31'd0, saw_wrap}, 32'd1);

    // Mid-operation reset at level 5 with overflow set.
    tick(1, 0, 4'b0000);
    for (int i = 0; i < 9; i++) tick(0, 1, 4'b0000);
    tick(0, 0, 4'b0010);
    tick(0, 0, 4'b0010);
    chk("midop_level", {28'd0, wr_level}, 32'd5);
    chk("midop_ovf", {31'd0, overflow}, 32'd1);
    tick(1, 0, 4'b0010);
    chk("midop_ovf_clr", {31'd0, overflow}, 32'd0);
    chk("midop_b_wptr", {28'd0, b_wptr}, 32'd0);
    tick(0, 1, 4'b0000);
    chk("post_rst_write", {28'd0, b_wptr}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wptr_handler.md
# wptr_handler

Write-side pointer and flag controller for the asynchronous FIFO, running entirely in the write clock domain. It advances the binary and Gray write pointers on accepted writes and synchronizes the read-domain Gray read pointer through a 2-flop synchronizer. From these it produces registered full, almost_full, fill-level and sticky overflow indications. It sits opposite the read-side pointer handler: its g_wptr feeds the read-domain synchronizer, and its w_inc and b_wptr drive the FIFO memory write port.

## Interface
- PTR_WIDTH, 3, address width; FIFO depth = 2^PTR_WIDTH; pointers are PTR_WIDTH+1 bits.
- AFULL_THRESH, 6, almost_full asserts when fill level ≥ this value; legal range 1..2^PTR_WIDTH.

- wclk  input  1  write clock.
- wrst  input  1  synchronous, active-high reset.
- w_en  input  1  write request.
- g_rptr  input  PTR_WIDTH+1  Gray read pointer, raw from the read domain (asynchronous).
- w_inc  output  1  write accepted this cycle; memory write enable.
- b_wptr  output  PTR_WIDTH+1  binary write pointer, registered.
- g_wptr  output  PTR_WIDTH+1  Gray write pointer, registered, to the read-domain synchronizer.
- g_rptr_sync  output  PTR_WIDTH+1  read pointer after the 2-flop synchronizer.
- full  output  1  registered full flag.
- almost_full  output  1  registered, level ≥ AFULL_THRESH.
- wr_level  output  PTR_WIDTH+1  registered fill level, 0..2^PTR_WIDTH.
- overflow  output  1  sticky; set by a write attempt while full.

## Operation
- Accept rule: w_inc = w_en & ~full & ~wrst (combinational from the registered full).
- b_wptr_next = b_wptr + w_inc, modulo 2^(PTR_WIDTH+1). g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next.
- Synchronizer: two wclk flops, sync1 <= g_rptr, then g_rptr_sync <= sync1. No logic between the stages.
- b_rptr_sync = Gray-to-binary of g_rptr_sync (prefix XOR from the MSB).
- level_next = b_wptr_next − b_rptr_sync, modulo 2^(PTR_WIDTH+1).
- full_next = (g_wptr_next == {~g_rptr_sync[MSB:MSB-1], g_rptr_sync[MSB-2:0]}). This is equivalent to level_next == 2^PTR_WIDTH, and both forms must agree.
- almost_full_next = (level_next ≥ AFULL_THRESH).
- All outputs except w_inc update on the wclk rising edge from the _next values.
- overflow <= overflow | (w_en & full). It is cleared only by wrst.
- Reset (wrst high at an edge): b_wptr, g_wptr, sync1, g_rptr_sync, wr_level = 0; full, almost_full, overflow = 0. w_inc = 0 while wrst is high.
- Reset mid-operation: all state clears on the next edge regardless of w_en. The synchronizer is flushed, so the read domain must be reset together with it.
- Wrap-around: pointers roll from 2^(PTR_WIDTH+1)−1 to 0 with no special handling. The Gray code changes exactly one bit per increment, including at the wrap.
- No state machine beyond the pointer registers; the block is a pipelined counter/compare.

## Timing
- Write acceptance to the b_wptr/g_wptr update: same edge (1 register stage).
- The full/almost_full/wr_level reflecting a write update on the same edge as the pointer.
- Read-domain g_rptr change to g_rptr_sync: 2 wclk edges. The flags and wr_level follow on the same edge as g_rptr_sync, i.e. 2 edges after g_rptr changes.
- Full is pessimistic: it may stay high up to 2 edges after the FIFO was actually drained. It never deasserts early.
- Simultaneous write and read-pointer update on one edge: the level nets both changes, e.g. 7 + 1 − 1 = 7, with no glitch on full.
- Write while full: no pointer change; overflow sets on that edge.

## Test plan
- Reset: hold wrst=1 for 2 cycles with w_en=1 and g_rptr=4'b0101 → every output is 0 and w_inc=0 throughout; after release, g_rptr_sync=4'b0101 2 edges later.
- Fill (depth 8, g_rptr=0, w_en=1 for 9 cycles):
  - b_wptr steps 1..8.
  - almost_full rises on the 6th write edge; g_wptr=4'b1100, full=1 and wr_level=8 on the 8th.
  - The 9th cycle gives w_inc=0, b_wptr stays 8, overflow=1.
- Drain visibility: from full, set g_rptr=4'b0001 → full=0 and wr_level=7 exactly 2 edges later; almost_full remains 1.
- Wrap: interleave writes and g_rptr advances for 20 writes → b_wptr goes 15→0 (g_wptr 4'b1000→4'b0000); wr_level always matches the expected count; full is never asserted falsely.
- Simultaneous: at wr_level=7, write on the edge where g_rptr_sync advances by 1 → wr_level stays 7; full=0.
- Mid-op reset: at wr_level=5 with overflow=1, pulse wrst for 1 cycle → next edge gives all zeros; overflow clears; a write in the following cycle gives b_wptr=1.
